// File: rtl/datapath_pkg.sv
// datapath_pkg: shared definitions for the single-bus CPU datapath.
//   word_t        32-bit bus / register word
//   OP_*          5-bit ALU opcodes
//   NUM_REGS      number of implemented general registers (R0..R3)
//   rotr32()      32-bit rotate-right helper used by the ALU
package datapath_pkg;

    typedef logic [31:0] word_t;

    localparam int NUM_REGS = 4;

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_AND = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_SHR = 5'b00111;
    localparam logic [4:0] OP_SHL = 5'b01000;
    localparam logic [4:0] OP_ROR = 5'b01001;
    localparam logic [4:0] OP_ROL = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NEG = 5'b10001;
    localparam logic [4:0] OP_NOT = 5'b10010;

    // Rotate right by 0..31; doubling the word avoids a 32-bit shift corner case.
    function automatic word_t rotr32(input word_t v, input logic [4:0] s);
        logic [63:0] dbl;
        dbl = {v, v} >> s;
        return dbl[31:0];
    endfunction

endpackage

// File: rtl/datapath_alu.sv
// alu: combinational ALU of the single-bus datapath.
//   a_i       operand A (Y register)
//   b_i       operand B (bus)
//   opcode_i  5-bit operation select
//   hi_o      upper result half (MUL high word / DIV remainder, else 0)
//   lo_o      lower result half
//   carry_o   bit 32 of ADD/SUB, 0 otherwise
// Optional feature macro: DATAPATH_MULDIV_EN enables signed MUL and DIV;
// without it both opcodes produce 0 and no multiplier/divider is built.
module alu
    import datapath_pkg::*;
(
    input  word_t      a_i,
    input  word_t      b_i,
    input  logic [4:0] opcode_i,
    output word_t      hi_o,
    output word_t      lo_o,
    output logic       carry_o
);

    logic [32:0] sum_s;
    logic [32:0] diff_s;
    logic [4:0]  shamt_s;

    assign sum_s   = {1'b0, a_i} + {1'b0, b_i};
    // SUB is A + ~B + 1 so that bit 32 is the carry (no-borrow) flag.
    assign diff_s  = {1'b0, a_i} + {1'b0, ~b_i} + 33'd1;
    assign shamt_s = b_i[4:0];

`ifdef DATAPATH_MULDIV_EN
    logic signed [63:0] prod_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;

    assign prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});

    // Signed divide; divide-by-zero forced to a zero quotient and remainder.
    always_comb begin
        quot_s = 32'sd0;
        rem_s  = 32'sd0;
        if (b_i == 32'd0) begin
            quot_s = 32'sd0;
            rem_s  = 32'sd0;
        end else begin
            quot_s = $signed(a_i) / $signed(b_i);
            rem_s  = $signed(a_i) % $signed(b_i);
        end
    end
`endif

    // Operation decode; hi stays 0 except for MUL/DIV.
    always_comb begin
        hi_o    = 32'd0;
        lo_o    = 32'd0;
        carry_o = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                lo_o    = sum_s[31:0];
                carry_o = sum_s[32];
            end
            OP_SUB: begin
                lo_o    = diff_s[31:0];
                carry_o = diff_s[32];
            end
            OP_AND: lo_o = a_i & b_i;
            OP_OR:  lo_o = a_i | b_i;
            OP_SHR: lo_o = a_i >> shamt_s;
            OP_SHL: lo_o = a_i << shamt_s;
            OP_ROR: lo_o = rotr32(a_i, shamt_s);
            // Rotate left by s equals rotate right by (32 - s) mod 32.
            OP_ROL: lo_o = rotr32(a_i, 5'd0 - shamt_s);
`ifdef DATAPATH_MULDIV_EN
            OP_MUL: begin
                hi_o = prod_s[63:32];
                lo_o = prod_s[31:0];
            end
            OP_DIV: begin
                hi_o = rem_s;
                lo_o = quot_s;
            end
`else
            OP_MUL, OP_DIV: begin
                hi_o = 32'd0;
                lo_o = 32'd0;
            end
`endif
            OP_NEG: lo_o = 32'd0 - b_i;
            OP_NOT: lo_o = ~b_i;
            default: begin
                hi_o    = 32'd0;
                lo_o    = 32'd0;
                carry_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/datapath.sv
// datapath: single-bus 32-bit CPU datapath (R0..R3, PC, IR, MAR, MDR, Y,
// HI, LO, 64-bit Z split as Zhigh/Zlow, carry flag) around one shared bus.
//   clock, clear          rising-edge clock, async active-high reset
//   Mdatain, Read         memory read data and MDR source select
//   *out, R0_15_out       bus source selects (priority mux, see below)
//   *in, R0in..R3in       register load enables
//   IncPC                 PC increment (qualified by PCin)
//   Cin                   carry flag load enable
//   opcode                ALU operation
//   BusMuxOut             current bus value
// Optional feature macro: DATAPATH_MULDIV_EN (MUL/DIV in the ALU).
module datapath
    import datapath_pkg::*;
(
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] Mdatain,
    input  logic        Read,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        HIout,
    input  logic        LOout,
    input  logic [15:0] R0_15_out,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        MDRin,
    input  logic        Yin,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        R0in,
    input  logic        R1in,
    input  logic        R2in,
    input  logic        R3in,
    input  logic        IncPC,
    input  logic        Cin,
    input  logic [4:0]  opcode,
    output logic [31:0] BusMuxOut
);

    word_t r_q [NUM_REGS];
    word_t r_d [NUM_REGS];
    word_t pc_q,  pc_d;
    word_t ir_q,  ir_d;
    word_t mar_q, mar_d;
    word_t mdr_q, mdr_d;
    word_t y_q,   y_d;
    word_t hi_q,  hi_d;
    word_t lo_q,  lo_d;
    word_t zhi_q, zhi_d;
    word_t zlo_q, zlo_d;
    logic  carry_q, carry_d;

    word_t bus_s;
    word_t alu_hi_s;
    word_t alu_lo_s;
    logic  alu_carry_s;
    logic  [NUM_REGS-1:0] rin_s;

    // IR and MAR feed blocks outside this slice; fold them so they count as read.
    logic unused_s;
    assign unused_s = ^{ir_q, mar_q};

    assign rin_s     = {R3in, R2in, R1in, R0in};
    assign BusMuxOut = bus_s;

    // Bus priority mux: R0..R15, HI, LO, Zhigh, Zlow, PC, MDR; R4..R15 read as 0.
    always_comb begin
        bus_s = 32'd0;
        if (R0_15_out[0]) begin
            bus_s = r_q[0];
        end else if (R0_15_out[1]) begin
            bus_s = r_q[1];
        end else if (R0_15_out[2]) begin
            bus_s = r_q[2];
        end else if (R0_15_out[3]) begin
            bus_s = r_q[3];
        end else if (|R0_15_out[15:4]) begin
            bus_s = 32'd0;
        end else if (HIout) begin
            bus_s = hi_q;
        end else if (LOout) begin
            bus_s = lo_q;
        end else if (Zhighout) begin
            bus_s = zhi_q;
        end else if (Zlowout) begin
            bus_s = zlo_q;
        end else if (PCout) begin
            bus_s = pc_q;
        end else if (MDRout) begin
            bus_s = mdr_q;
        end else begin
            bus_s = 32'd0;
        end
    end

    alu u_alu (
        .a_i      (y_q),
        .b_i      (bus_s),
        .opcode_i (opcode),
        .hi_o     (alu_hi_s),
        .lo_o     (alu_lo_s),
        .carry_o  (alu_carry_s)
    );

    // Next-state selection; a non-1 enable holds the register.
    always_comb begin
        for (int n = 0; n < NUM_REGS; n++) begin
            if (rin_s[n]) begin
                r_d[n] = bus_s;
            end else begin
                r_d[n] = r_q[n];
            end
        end

        if (PCin && IncPC) begin
            pc_d = pc_q + 32'd1;
        end else if (PCin) begin
            pc_d = bus_s;
        end else begin
            pc_d = pc_q;
        end

        if (MDRin && Read) begin
            mdr_d = Mdatain;
        end else if (MDRin) begin
            mdr_d = bus_s;
        end else begin
            mdr_d = mdr_q;
        end

        if (IRin)    begin ir_d  = bus_s;       end else begin ir_d  = ir_q;  end
        if (MARin)   begin mar_d = bus_s;       end else begin mar_d = mar_q; end
        if (Yin)     begin y_d   = bus_s;       end else begin y_d   = y_q;   end
        if (HIin)    begin hi_d  = bus_s;       end else begin hi_d  = hi_q;  end
        if (LOin)    begin lo_d  = bus_s;       end else begin lo_d  = lo_q;  end
        if (Zhighin) begin zhi_d = alu_hi_s;    end else begin zhi_d = zhi_q; end
        if (Zlowin)  begin zlo_d = alu_lo_s;    end else begin zlo_d = zlo_q; end
        if (Cin)     begin carry_d = alu_carry_s; end else begin carry_d = carry_q; end
    end

    // State registers; clear wins over every enable.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            for (int n = 0; n < NUM_REGS; n++) begin
                r_q[n] <= 32'd0;
            end
            pc_q    <= 32'd0;
            ir_q    <= 32'd0;
            mar_q   <= 32'd0;
            mdr_q   <= 32'd0;
            y_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            zhi_q   <= 32'd0;
            zlo_q   <= 32'd0;
            carry_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_REGS; n++) begin
                r_q[n] <= r_d[n];
            end
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            carry_q <= carry_d;
        end
    end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: directed and randomized bench for datapath with a
// behavioural model of registers, bus priority and ALU arithmetic.
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        Read, PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic [15:0] R0_15_out;
    logic        PCin, IRin, MARin, MDRin, Yin, HIin, LOin, Zhighin, Zlowin;
    logic        R0in, R1in, R2in, R3in, IncPC, Cin;
    logic [4:0]  opcode;
    logic [31:0] BusMuxOut;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [31:0] r_m [4];
    logic [31:0] pc_m, ir_m, mar_m, mdr_m, y_m, hi_m, lo_m, zh_m, zl_m;
    logic        c_m;

    always #5 clock = ~clock;

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .R0_15_out(R0_15_out),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .R0in(R0in), .R1in(R1in), .R2in(R2in), .R3in(R3in),
        .IncPC(IncPC), .Cin(Cin), .opcode(opcode), .BusMuxOut(BusMuxOut)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) r_m[n] = 32'd0;
        pc_m = 32'd0; ir_m = 32'd0; mar_m = 32'd0; mdr_m = 32'd0; y_m = 32'd0;
        hi_m = 32'd0; lo_m = 32'd0; zh_m = 32'd0; zl_m = 32'd0; c_m = 1'b0;
    endtask

    task automatic idle();
        Read = 1'b0; PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; R0_15_out = 16'd0;
        PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
        HIin = 1'b0; LOin = 1'b0; Zhighin = 1'b0; Zlowin = 1'b0;
        R0in = 1'b0; R1in = 1'b0; R2in = 1'b0; R3in = 1'b0;
        IncPC = 1'b0; Cin = 1'b0; opcode = 5'd0;
    endtask

    // Bus value by the priority rule: first asserted of R0..R15, HI, LO, Zhigh, Zlow, PC, MDR.
    function automatic logic [31:0] bus_ref();
        for (int n = 0; n < 16; n++)
            if (R0_15_out[n] === 1'b1) return (n < 4) ? r_m[n] : 32'd0;
        if (HIout === 1'b1)    return hi_m;
        if (LOout === 1'b1)    return lo_m;
        if (Zhighout === 1'b1) return zh_m;
        if (Zlowout === 1'b1)  return zl_m;
        if (PCout === 1'b1)    return pc_m;
        if (MDRout === 1'b1)   return mdr_m;
        return 32'd0;
    endfunction

    // Returns {carry, hi, lo}.
    function automatic logic [64:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op);
        longint      s;
        logic [63:0] dbl;
        logic [31:0] hi, lo;
        logic        c;
        int          qa, qb;
        hi = 32'd0; lo = 32'd0; c = 1'b0;
        case (op)
            5'b00011: begin s = longint'(a) + longint'(b); lo = a + b; c = (s > 64'hFFFF_FFFF); end
            5'b00100: begin lo = a - b; c = (a >= b); end
            5'b00101: lo = a & b;
            5'b00110: lo = a | b;
            5'b00111: lo = a >> b[4:0];
            5'b01000: lo = a << b[4:0];
            5'b01001: begin dbl = {a, a} >> b[4:0]; lo = dbl[31:0]; end
            5'b01010: begin dbl = {a, a} << b[4:0]; lo = dbl[63:32]; end
`ifdef DATAPATH_MULDIV_EN
            5'b01111: begin
                s = longint'($signed(a)) * longint'($signed(b));
                dbl = s; hi = dbl[63:32]; lo = dbl[31:0];
            end
            5'b10000: begin
                if (b != 32'd0) begin
                    qa = $signed(a); qb = $signed(b);
                    lo = qa / qb; hi = qa % qb;
                end
            end
`endif
            5'b10001: lo = 32'd0 - b;
            5'b10010: lo = ~b;
            default: begin hi = 32'd0; lo = 32'd0; end
        endcase
        return {c, hi, lo};
    endfunction

    // One clock: check the bus before the edge, then advance the model.
    task automatic cyc();
        logic [31:0] b;
        logic [64:0] res;
        @(negedge clock);
        #1;
        b = bus_ref();
        chk("bus", {32'd0, BusMuxOut}, {32'd0, b});
        res = alu_ref(y_m, b, opcode);
        @(posedge clock);
        if (R0in === 1'b1) r_m[0] = b;
        if (R1in === 1'b1) r_m[1] = b;
        if (R2in === 1'b1) r_m[2] = b;
        if (R3in === 1'b1) r_m[3] = b;
        if (PCin === 1'b1) pc_m = (IncPC === 1'b1) ? pc_m + 32'd1 : b;
        if (MDRin === 1'b1) mdr_m = (Read === 1'b1) ? Mdatain : b;
        if (IRin === 1'b1)  ir_m  = b;
        if (MARin === 1'b1) mar_m = b;
        if (Yin === 1'b1)   y_m   = b;
        if (HIin === 1'b1)  hi_m  = b;
        if (LOin === 1'b1)  lo_m  = b;
        if (Zhighin === 1'b1) zh_m = res[63:32];
        if (Zlowin === 1'b1)  zl_m = res[31:0];
        if (Cin === 1'b1)     c_m  = res[64];
        #1;
    endtask

    task automatic set_src(input int s);
        PCout = 1'b0; MDRout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
        HIout = 1'b0; LOout = 1'b0; R0_15_out = 16'd0;
        case (s)
            0, 1, 2, 3: R0_15_out[s] = 1'b1;
            4: HIout = 1'b1;
            5: LOout = 1'b1;
            6: Zhighout = 1'b1;
            7: Zlowout = 1'b1;
            8: PCout = 1'b1;
            9: MDRout = 1'b1;
            default: R0_15_out = 16'd0;
        endcase
    endtask

    function automatic logic [31:0] src_model(input int s);
        case (s)
            0, 1, 2, 3: return r_m[s];
            4: return hi_m;
            5: return lo_m;
            6: return zh_m;
            7: return zl_m;
            8: return pc_m;
            9: return mdr_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic peek_const(input string tag, input int s, input logic [31:0] v);
        idle();
        set_src(s);
        #1;
        chk(tag, {32'd0, BusMuxOut}, {32'd0, v});
        idle();
    endtask

    task automatic peek_all();
        idle();
        for (int s = 0; s < 10; s++) begin
            set_src(s);
            #1;
            chk($sformatf("src%0d", s), {32'd0, BusMuxOut}, {32'd0, src_model(s)});
        end
        idle();
        #1;
        chk("nosel", {32'd0, BusMuxOut}, 64'd0);
        chk("ir",    {32'd0, dut.ir_q},  {32'd0, ir_m});
        chk("mar",   {32'd0, dut.mar_q}, {32'd0, mar_m});
        chk("y",     {32'd0, dut.y_q},   {32'd0, y_m});
        chk("carry", {63'd0, dut.carry_q}, {63'd0, c_m});
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); Mdatain = v; Read = 1'b1; MDRin = 1'b1; cyc(); idle();
    endtask

    // Y <- a, then Z <- ALU(a, b) with carry load.
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        load_mdr(a);
        MDRout = 1'b1; Yin = 1'b1; cyc(); idle();
        load_mdr(b);
        MDRout = 1'b1; opcode = op; Zhighin = 1'b1; Zlowin = 1'b1; Cin = 1'b1; cyc(); idle();
    endtask

    initial begin
        logic [31:0] b;
        idle();
        Mdatain = 32'd0;
        model_reset();
        clear = 1'b1;
        #12;
        clear = 1'b0;
        @(posedge clock); #1;
        peek_all();

        // register loads through MDR
        load_mdr(32'h12); MDRout = 1'b1; R2in = 1'b1; cyc(); idle();
        load_mdr(32'h14); MDRout = 1'b1; R3in = 1'b1; cyc(); idle();
        load_mdr(32'h18); MDRout = 1'b1; R1in = 1'b1; cyc(); idle();
        peek_const("R2_ld", 2, 32'h12);
        peek_const("R3_ld", 3, 32'h14);
        peek_const("R1_ld", 1, 32'h18);

        // fetch
        PCin = 1'b1; IncPC = 1'b1; cyc(); idle();
        peek_const("pc_inc", 8, 32'd1);
        load_mdr(32'h2891_8000); MDRout = 1'b1; IRin = 1'b1; cyc(); idle();
        chk("ir_ld", {32'd0, dut.ir_q}, {32'd0, 32'h2891_8000});

        // ADD R1 = R2 + R3
        R0_15_out = 16'h0004; Yin = 1'b1; cyc(); idle();
        R0_15_out = 16'h0008; opcode = 5'b00011; Zlowin = 1'b1; cyc(); idle();
        Zlowout = 1'b1; R1in = 1'b1;
        #1; chk("add_bus", {32'd0, BusMuxOut}, {32'd0, 32'h26});
        cyc(); idle();
        peek_const("add_R1", 1, 32'h26);
        peek_all();

        // MUL / DIV
        alu_op(32'hFFFF_FFFF, 32'd2, 5'b01111);
`ifdef DATAPATH_MULDIV_EN
        peek_const("mul_hi", 6, 32'hFFFF_FFFF); peek_const("mul_lo", 7, 32'hFFFF_FFFE);
`else
        peek_const("mul_hi", 6, 32'd0); peek_const("mul_lo", 7, 32'd0);
`endif
        alu_op(32'd7, 32'd2, 5'b10000);
`ifdef DATAPATH_MULDIV_EN
        peek_const("div_hi", 6, 32'd1); peek_const("div_lo", 7, 32'd3);
`else
        peek_const("div_hi", 6, 32'd0); peek_const("div_lo", 7, 32'd0);
`endif
        alu_op(32'd9, 32'd0, 5'b10000);
        peek_const("div0_hi", 6, 32'd0); peek_const("div0_lo", 7, 32'd0);

        // carry and PC wrap
        alu_op(32'hFFFF_FFFF, 32'd1, 5'b00011);
        peek_const("addc_lo", 7, 32'd0);
        chk("addc_c", {63'd0, dut.carry_q}, 64'd1);
        alu_op(32'd5, 32'd3, 5'b00100);
        chk("subc_c", {63'd0, dut.carry_q}, 64'd1);
        load_mdr(32'hFFFF_FFFF); MDRout = 1'b1; PCin = 1'b1; cyc(); idle();
        PCin = 1'b1; IncPC = 1'b1; cyc(); idle();
        peek_const("pc_wrap", 8, 32'd0);
        // MDR loading itself while driving the bus holds its value
        MDRout = 1'b1; MDRin = 1'b1; cyc(); idle();
        peek_const("mdr_hold", 9, 32'hFFFF_FFFF);
        peek_all();

        // randomized operation
        for (int i = 0; i < 80; i++) begin
            idle();
            case ($urandom_range(3, 0))
                0: R0_15_out = 16'd0;
                1: R0_15_out = 16'd1 << $urandom_range(3, 0);
                2: R0_15_out = 16'd1 << $urandom_range(3, 0);
                default: R0_15_out = 16'($urandom);
            endcase
            HIout = ($urandom_range(3, 0) == 0); LOout = ($urandom_range(3, 0) == 0);
            Zhighout = ($urandom_range(3, 0) == 0); Zlowout = ($urandom_range(3, 0) == 0);
            PCout = ($urandom_range(3, 0) == 0); MDRout = ($urandom_range(1, 0) == 0);
            Read = $urandom_range(1, 0); Mdatain = $urandom;
            PCin = ($urandom_range(3, 0) == 0); IncPC = $urandom_range(1, 0);
            IRin = ($urandom_range(3, 0) == 0); MARin = ($urandom_range(3, 0) == 0);
            MDRin = ($urandom_range(2, 0) == 0); Yin = ($urandom_range(2, 0) == 0);
            HIin = ($urandom_range(3, 0) == 0); LOin = ($urandom_range(3, 0) == 0);
            Zhighin = ($urandom_range(2, 0) == 0); Zlowin = ($urandom_range(2, 0) == 0);
            R0in = ($urandom_range(2, 0) == 0); R1in = ($urandom_range(2, 0) == 0);
            R2in = ($urandom_range(2, 0) == 0); R3in = ($urandom_range(2, 0) == 0);
            Cin = $urandom_range(1, 0);
            opcode = (i % 4 == 3) ? 5'($urandom) : 5'($urandom_range(18, 3));
            b = bus_ref();
            // avoid the signed-division overflow corner
            if (opcode == 5'b10000 && y_m == 32'h8000_0000 && b == 32'hFFFF_FFFF) opcode = 5'b00011;
            cyc();
            if (i % 8 == 7) peek_all();
        end
        peek_all();

        // asynchronous clear mid-operation
        load_mdr(32'h55); MDRout = 1'b1; R1in = 1'b1; cyc(); idle();
        peek_const("R1_pre", 1, 32'h55);
        MDRout = 1'b1; R1in = 1'b1; PCin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; opcode = 5'b00011;
        @(negedge clock);
        clear = 1'b1;
        #1;
        model_reset();
        peek_all();
        MDRout = 1'b1; R1in = 1'b1; PCin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1; opcode = 5'b00011;
        @(posedge clock); #1;
        peek_all();
        clear = 1'b0;
        peek_const("R1_clr", 1, 32'd0);
        peek_const("pc_clr", 8, 32'd0);
        peek_const("zl_clr", 7, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
